cn_core_xbar: RTL and testbench

Parametrised host-to-core interconnect for the CryptoNight hash array. It fans one host register port (32-bit) and one host memory port (MEM_DW-bit) out to CORE_NUM cn_top cores and returns selected read data with an explicit valid pulse. It adds broadcast writes, out-of-range detection with a saturating error counter, and a sticky done mask. Sits between the host bridge and the generate-loop of cn_top instances.

---
 rtl/cn_xbar_pkg.sv | 21 ++
 rtl/cn_core_xbar_if.sv | 37 +++
 rtl/cn_xbar_rdpipe.sv | 37 +++
 rtl/cn_core_xbar.sv | 166 ++++++++++++++++
 tb/tb_cn_core_xbar.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cn_xbar_pkg.sv
// cn_xbar_pkg: shared constants and helpers for the cn_core_xbar slice.
// Optional macro CN_XBAR_BCAST_EN makes core index 4'hF a broadcast/status index.
package cn_xbar_pkg;

  localparam int          CORE_SEL_W   = 4;
  localparam logic [3:0]  BCAST_IDX    = 4'hF;
  localparam logic [31:0] REG_ERR_WORD = 32'hDEAD_C0DE;
  localparam int          ERR_CNT_W    = 8;

  // True when idx addresses no core (broadcast index is never out of range).
  function automatic logic idx_oor(
    input logic [CORE_SEL_W-1:0] idx,
    input int                    core_num
  );
`ifdef CN_XBAR_BCAST_EN
    if (idx == BCAST_IDX) return 1'b0;
`endif
    return int'(idx) >= core_num;
  endfunction

endpackage

// File: rtl/cn_core_xbar_if.sv
// cn_core_xbar_if: host register port (32-bit) and host memory port (MEM_DW).
// master = host bridge side, slave = crossbar side.
interface cn_core_xbar_if #(
  parameter int REG_AW = 10,
  parameter int MEM_AW = 17,
  parameter int MEM_DW = 128
);

  logic [REG_AW+3:0] reg_address;
  logic              reg_write;
  logic              reg_read;
  logic [31:0]       reg_wrdata;
  logic [31:0]       reg_rddata;
  logic              reg_rdvalid;

  logic [MEM_AW+3:0] mem_address;
  logic              mem_write;
  logic              mem_read;
  logic [MEM_DW-1:0] mem_wrdata;
  logic [MEM_DW-1:0] mem_rddata;
  logic              mem_rdvalid;

  modport master (
    output reg_address, reg_write, reg_read, reg_wrdata,
    input  reg_rddata, reg_rdvalid,
    output mem_address, mem_write, mem_read, mem_wrdata,
    input  mem_rddata, mem_rdvalid
  );

  modport slave (
    input  reg_address, reg_write, reg_read, reg_wrdata,
    output reg_rddata, reg_rdvalid,
    input  mem_address, mem_write, mem_read, mem_wrdata,
    output mem_rddata, mem_rdvalid
  );

endinterface

// File: rtl/cn_xbar_rdpipe.sv
// cn_xbar_rdpipe: DEPTH-stage shift register of {valid, core idx, oor flag}.
// Ports: clk, reset_n, valid_i/idx_i/oor_i in, valid_o/idx_o/oor_o from last stage.
module cn_xbar_rdpipe #(
  parameter int DEPTH = 3,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_i,
  input  logic [SEL_W-1:0] idx_i,
  input  logic             oor_i,
  output logic             valid_o,
  output logic [SEL_W-1:0] idx_o,
  output logic             oor_o
);

  logic [DEPTH-1:0]            v_q;
  logic [DEPTH-1:0]            oor_q;
  logic [DEPTH-1:0][SEL_W-1:0] idx_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q   <= '0;
      oor_q <= '0;
      idx_q <= '0;
    end else begin
      v_q   <= {v_q[DEPTH-2:0], valid_i};
      oor_q <= {oor_q[DEPTH-2:0], oor_i};
      idx_q <= {idx_q[DEPTH-2:0], idx_i};
    end
  end

  assign valid_o = v_q[DEPTH-1];
  assign idx_o   = idx_q[DEPTH-1];
  assign oor_o   = oor_q[DEPTH-1];

endmodule

// File: rtl/cn_core_xbar.sv
// cn_core_xbar: host-to-core crossbar; fans host reg/mem ports (host) out to
// CORE_NUM cores (core_*), returns read data with *_rdvalid, keeps sts_* status.
// Optional macro CN_XBAR_BCAST_EN: idx 4'hF broadcasts writes / reads status.
module cn_core_xbar
  import cn_xbar_pkg::*;
#(
  parameter int CORE_NUM = 4,
  parameter int REG_AW   = 10,
  parameter int MEM_AW   = 17,
  parameter int MEM_DW   = 128,
  parameter int RD_LAT   = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  cn_core_xbar_if.slave              host,
  output logic [REG_AW-1:0]          core_reg_address,
  output logic [31:0]                core_reg_wrdata,
  output logic [CORE_NUM-1:0]        core_reg_write,
  input  logic [32*CORE_NUM-1:0]     core_reg_rddata,
  output logic [MEM_AW-1:0]          core_mem_address,
  output logic [MEM_DW-1:0]          core_mem_wrdata,
  output logic [CORE_NUM-1:0]        core_mem_write,
  input  logic [MEM_DW*CORE_NUM-1:0] core_mem_rddata,
  input  logic [CORE_NUM-1:0]        core_done,
  input  logic                       sts_clr,
  output logic [CORE_NUM-1:0]        sts_done_mask,
  output logic [ERR_CNT_W-1:0]       sts_err_cnt
);

  localparam int DEPTH = 1 + RD_LAT;
  localparam int SW    = CORE_SEL_W;

  logic [SW-1:0] reg_idx, mem_idx;
  logic          reg_oor, mem_oor;
  logic          reg_bc, mem_bc;

  assign reg_idx = host.reg_address[REG_AW+SW-1:REG_AW];
  assign mem_idx = host.mem_address[MEM_AW+SW-1:MEM_AW];
  assign reg_oor = idx_oor(reg_idx, CORE_NUM);
  assign mem_oor = idx_oor(mem_idx, CORE_NUM);

`ifdef CN_XBAR_BCAST_EN
  assign reg_bc = (reg_idx == BCAST_IDX);
  assign mem_bc = (mem_idx == BCAST_IDX);
`else
  assign reg_bc = 1'b0;
  assign mem_bc = 1'b0;
`endif

  // Stage 1: address, data and decoded write strobes
  logic [REG_AW-1:0]   reg_addr_q;
  logic [31:0]         reg_wdat_q;
  logic [CORE_NUM-1:0] reg_wsel_d, reg_wsel_q;
  logic [MEM_AW-1:0]   mem_addr_q;
  logic [MEM_DW-1:0]   mem_wdat_q;
  logic [CORE_NUM-1:0] mem_wsel_d, mem_wsel_q;

  always_comb begin
    reg_wsel_d = '0;
    mem_wsel_d = '0;
    for (int i = 0; i < CORE_NUM; i++) begin
      if (host.reg_write && (reg_bc || reg_idx == SW'(i)))
        reg_wsel_d[i] = 1'b1;
      if (host.mem_write && (mem_bc || mem_idx == SW'(i)))
        mem_wsel_d[i] = 1'b1;
    end
  end

  // Status: sticky done mask, saturating error count (clear wins)
  logic [CORE_NUM-1:0]  mask_d, mask_q;
  logic [ERR_CNT_W-1:0] err_d, err_q;
  logic [2:0]           err_inc;
  logic [ERR_CNT_W:0]   err_sum;

  assign err_inc = 3'(host.reg_write & reg_oor) + 3'(host.reg_read & reg_oor)
                 + 3'(host.mem_write & mem_oor) + 3'(host.mem_read & mem_oor);
  assign err_sum = {1'b0, err_q} + (ERR_CNT_W+1)'(err_inc);

  always_comb begin
    mask_d = mask_q | core_done;
    err_d  = err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
    if (sts_clr) begin
      mask_d = '0;
      err_d  = '0;
    end
  end

  // Read select pipelines, aligned to core read latency
  logic          rp_v, mp_v, rp_oor, mp_oor;
  logic [SW-1:0] rp_idx, mp_idx;

  cn_xbar_rdpipe #(.DEPTH(DEPTH), .SEL_W(SW)) u_reg_pipe (
    .clk(clk), .reset_n(reset_n),
    .valid_i(host.reg_read), .idx_i(reg_idx), .oor_i(reg_oor),
    .valid_o(rp_v), .idx_o(rp_idx), .oor_o(rp_oor)
  );

  cn_xbar_rdpipe #(.DEPTH(DEPTH), .SEL_W(SW)) u_mem_pipe (
    .clk(clk), .reset_n(reset_n),
    .valid_i(host.mem_read), .idx_i(mem_idx), .oor_i(mem_oor),
    .valid_o(mp_v), .idx_o(mp_idx), .oor_o(mp_oor)
  );

  logic [31:0]     reg_rd_d, reg_rd_q;
  logic [MEM_DW-1:0] mem_rd_d, mem_rd_q;
  logic            reg_vld_q, mem_vld_q;

  // Broadcast idx on mem path matches no core, so it reads 0
  always_comb begin
    reg_rd_d = '0;
    mem_rd_d = '0;
    for (int i = 0; i < CORE_NUM; i++) begin
      if (rp_idx == SW'(i)) reg_rd_d = core_reg_rddata[32*i +: 32];
      if (mp_idx == SW'(i)) mem_rd_d = core_mem_rddata[MEM_DW*i +: MEM_DW];
    end
`ifdef CN_XBAR_BCAST_EN
    if (rp_idx == BCAST_IDX) reg_rd_d = 32'(mask_q);
`endif
    if (rp_oor) reg_rd_d = REG_ERR_WORD;
    if (mp_oor) mem_rd_d = '1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_addr_q <= '0;
      reg_wdat_q <= '0;
      reg_wsel_q <= '0;
      mem_addr_q <= '0;
      mem_wdat_q <= '0;
      mem_wsel_q <= '0;
      mask_q     <= '0;
      err_q      <= '0;
      reg_vld_q  <= 1'b0;
      mem_vld_q  <= 1'b0;
      reg_rd_q   <= '0;
      mem_rd_q   <= '0;
    end else begin
      reg_addr_q <= host.reg_address[REG_AW-1:0];
      reg_wdat_q <= host.reg_wrdata;
      reg_wsel_q <= reg_wsel_d;
      mem_addr_q <= host.mem_address[MEM_AW-1:0];
      mem_wdat_q <= host.mem_wrdata;
      mem_wsel_q <= mem_wsel_d;
      mask_q     <= mask_d;
      err_q      <= err_d;
      reg_vld_q  <= rp_v;
      mem_vld_q  <= mp_v;
      if (rp_v) reg_rd_q <= reg_rd_d;
      if (mp_v) mem_rd_q <= mem_rd_d;
    end
  end

  assign core_reg_address = reg_addr_q;
  assign core_reg_wrdata  = reg_wdat_q;
  assign core_reg_write   = reg_wsel_q;
  assign core_mem_address = mem_addr_q;
  assign core_mem_wrdata  = mem_wdat_q;
  assign core_mem_write   = mem_wsel_q;
  assign host.reg_rddata  = reg_rd_q;
  assign host.reg_rdvalid = reg_vld_q;
  assign host.mem_rddata  = mem_rd_q;
  assign host.mem_rdvalid = mem_vld_q;
  assign sts_done_mask    = mask_q;
  assign sts_err_cnt      = err_q;

endmodule

// File: tb/tb_cn_core_xbar.sv
// tb_cn_core_xbar: directed + random stimulus against a queue-based model.
// Covers writes, in-order reads, error counting, done mask, reset flush.
module tb_cn_core_xbar;

  localparam int CORE_NUM = 4;
  localparam int REG_AW   = 10;
  localparam int MEM_AW   = 17;
  localparam int MEM_DW   = 128;
  localparam int RD_LAT   = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cn_core_xbar_if #(.REG_AW(REG_AW), .MEM_AW(MEM_AW), .MEM_DW(MEM_DW)) hif ();

  logic [REG_AW-1:0]          core_reg_address;
  logic [31:0]                core_reg_wrdata;
  logic [CORE_NUM-1:0]        core_reg_write;
  logic [32*CORE_NUM-1:0]     core_reg_rddata;
  logic [MEM_AW-1:0]          core_mem_address;
  logic [MEM_DW-1:0]          core_mem_wrdata;
  logic [CORE_NUM-1:0]        core_mem_write;
  logic [MEM_DW*CORE_NUM-1:0] core_mem_rddata;
  logic [CORE_NUM-1:0]        core_done;
  logic                       sts_clr;
  logic [CORE_NUM-1:0]        sts_done_mask;
  logic [7:0]                 sts_err_cnt;

  cn_core_xbar #(
    .CORE_NUM(CORE_NUM), .REG_AW(REG_AW), .MEM_AW(MEM_AW),
    .MEM_DW(MEM_DW), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .host(hif),
    .core_reg_address(core_reg_address), .core_reg_wrdata(core_reg_wrdata),
    .core_reg_write(core_reg_write), .core_reg_rddata(core_reg_rddata),
    .core_mem_address(core_mem_address), .core_mem_wrdata(core_mem_wrdata),
    .core_mem_write(core_mem_write), .core_mem_rddata(core_mem_rddata),
    .core_done(core_done), .sts_clr(sts_clr),
    .sts_done_mask(sts_done_mask), .sts_err_cnt(sts_err_cnt)
  );

  typedef struct { int due; logic [127:0] d; } rd_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int m_err = 0;
  logic [CORE_NUM-1:0] m_mask = '0;
  logic [127:0] mem_core [CORE_NUM];
  rd_t rq[$];
  rd_t mq[$];

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_bc(input logic [3:0] idx);
`ifdef CN_XBAR_BCAST_EN
    return idx == 4'hF;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic m_oor(input logic [3:0] idx);
    return !m_bc(idx) && (int'(idx) >= CORE_NUM);
  endfunction

  function automatic logic [CORE_NUM-1:0] m_wsel(input logic wr,
                                                 input logic [3:0] idx);
    logic [CORE_NUM-1:0] v;
    v = '0;
    if (wr && m_bc(idx)) v = '1;
    else if (wr && !m_oor(idx)) v[idx] = 1'b1;
    return v;
  endfunction

  // One clock: predict from current inputs, advance, compare.
  task automatic step();
    logic [3:0] ri, mi;
    logic [CORE_NUM-1:0] e_rw, e_mw, mask_n;
    logic [REG_AW-1:0] e_ra;
    logic [MEM_AW-1:0] e_ma;
    logic [31:0] e_rd, e_rwd;
    logic [127:0] e_md, e_mwd;
    int inc, err_n;
    ri = hif.reg_address[REG_AW+3:REG_AW];
    mi = hif.mem_address[MEM_AW+3:MEM_AW];
    e_rw = m_wsel(hif.reg_write, ri);
    e_mw = m_wsel(hif.mem_write, mi);
    e_ra = hif.reg_address[REG_AW-1:0];
    e_ma = hif.mem_address[MEM_AW-1:0];
    e_rwd = hif.reg_wrdata;
    e_mwd = hif.mem_wrdata;
    inc = 0;
    if (hif.reg_write && m_oor(ri)) inc++;
    if (hif.mem_write && m_oor(mi)) inc++;
    if (hif.reg_read) begin
      if (m_oor(ri)) begin inc++; e_rd = 32'hDEAD_C0DE; end
      else if (m_bc(ri)) e_rd = 32'(m_mask);
      else e_rd = 32'hC000_0000 + 32'(ri);
      rq.push_back('{cyc + 2 + RD_LAT, 128'(e_rd)});
    end
    if (hif.mem_read) begin
      if (m_oor(mi)) begin inc++; e_md = '1; end
      else if (m_bc(mi)) e_md = '0;
      else e_md = mem_core[mi];
      mq.push_back('{cyc + 2 + RD_LAT, e_md});
    end
    err_n  = sts_clr ? 0 : ((m_err + inc > 255) ? 255 : m_err + inc);
    mask_n = sts_clr ? '0 : (m_mask | core_done);
    @(posedge clk); #1;
    cyc++;
    chk("core_reg_write", 128'(core_reg_write), 128'(e_rw));
    chk("core_mem_write", 128'(core_mem_write), 128'(e_mw));
    chk("core_reg_address", 128'(core_reg_address), 128'(e_ra));
    chk("core_mem_address", 128'(core_mem_address), 128'(e_ma));
    chk("core_reg_wrdata", 128'(core_reg_wrdata), 128'(e_rwd));
    chk("core_mem_wrdata", core_mem_wrdata, e_mwd);
    chk("sts_err_cnt", 128'(sts_err_cnt), 128'(err_n));
    chk("sts_done_mask", 128'(sts_done_mask), 128'(mask_n));
    m_err = err_n;
    m_mask = mask_n;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      chk("reg_rdvalid", 128'(hif.reg_rdvalid), 128'(1));
      chk("reg_rddata", 128'(hif.reg_rddata), rq[0].d);
      void'(rq.pop_front());
    end else chk("reg_rdvalid_idle", 128'(hif.reg_rdvalid), 128'(0));
    if (mq.size() > 0 && mq[0].due == cyc) begin
      chk("mem_rdvalid", 128'(hif.mem_rdvalid), 128'(1));
      chk("mem_rddata", hif.mem_rddata, mq[0].d);
      void'(mq.pop_front());
    end else chk("mem_rdvalid_idle", 128'(hif.mem_rdvalid), 128'(0));
  endtask

  task automatic idle();
    hif.reg_write = 0; hif.reg_read = 0;
    hif.mem_write = 0; hif.mem_read = 0;
    sts_clr = 0;
  endtask

  task automatic set_reg(input logic w, input logic r, input logic [3:0] idx,
                         input logic [REG_AW-1:0] a, input logic [31:0] d);
    hif.reg_write = w; hif.reg_read = r;
    hif.reg_address = {idx, a}; hif.reg_wrdata = d;
  endtask

  task automatic set_mem(input logic w, input logic r, input logic [3:0] idx,
                         input logic [MEM_AW-1:0] a, input logic [127:0] d);
    hif.mem_write = w; hif.mem_read = r;
    hif.mem_address = {idx, a}; hif.mem_wrdata = d;
  endtask

  initial begin
    for (int i = 0; i < CORE_NUM; i++) begin
      mem_core[i] = {$urandom, $urandom, $urandom, $urandom};
      core_reg_rddata[32*i +: 32] = 32'hC000_0000 + 32'(i);
      core_mem_rddata[MEM_DW*i +: MEM_DW] = mem_core[i];
    end
    core_done = '0;
    idle();
    set_reg(0, 0, 0, '0, '0);
    set_mem(0, 0, 0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_reg_rdvalid", 128'(hif.reg_rdvalid), 128'(0));
    chk("rst_reg_rddata", 128'(hif.reg_rddata), 128'(0));
    chk("rst_mem_rdvalid", 128'(hif.mem_rdvalid), 128'(0));
    chk("rst_mem_rddata", hif.mem_rddata, 128'(0));
    chk("rst_core_reg_write", 128'(core_reg_write), 128'(0));
    chk("rst_err", 128'(sts_err_cnt), 128'(0));
    chk("rst_mask", 128'(sts_done_mask), 128'(0));
    reset_n = 1'b1;

    // Directed write idx 2 addr 0x10
    set_reg(1, 0, 4'd2, 10'h010, 32'h1234_5678);
    step();
    chk("wr_idx2_pulse", 128'(core_reg_write), 128'(4'b0100));
    idle();
    step();

    // Back-to-back reads idx 0..3
    for (int i = 0; i < 4; i++) begin
      set_reg(0, 1, 4'(i), 10'(i), '0);
      step();
    end
    idle();
    repeat (6) step();

    // Mem read idx 7: all-ones, one error
    set_mem(0, 1, 4'd7, '0, '0);
    step();
    idle();
    repeat (5) step();
    chk("err_after_mem7", 128'(sts_err_cnt), 128'(1));

    // Saturation: 300 mem errors
    for (int i = 0; i < 300; i++) begin
      set_mem(1, 0, 4'd9, 17'(i), '0);
      step();
    end
    idle();
    step();
    chk("err_saturated", 128'(sts_err_cnt), 128'(255));

    // Clear coincident with two errors
    set_reg(1, 0, 4'd5, '0, '0);
    set_mem(1, 0, 4'd6, '0, '0);
    sts_clr = 1;
    step();
    chk("clr_wins", 128'(sts_err_cnt), 128'(0));
    idle();
    step();

    // Done mask sticky
    core_done = 4'b0101;
    step();
    core_done = '0;
    repeat (2) step();
    chk("mask_sticky", 128'(sts_done_mask), 128'(4'b0101));

`ifdef CN_XBAR_BCAST_EN
    set_reg(1, 0, 4'hF, 10'h3, 32'hA5A5_A5A5);
    step();
    chk("bcast_write", 128'(core_reg_write), 128'(4'b1111));
    set_reg(0, 1, 4'hF, '0, '0);
    set_mem(0, 1, 4'hF, '0, '0);
    step();
    idle();
    repeat (5) step();
`endif

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      set_reg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 7)), 10'($urandom), $urandom);
      set_mem(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 7)), 17'($urandom),
              {$urandom, $urandom, $urandom, $urandom});
      sts_clr = ($urandom_range(0, 40) == 0);
      core_done = ($urandom_range(0, 9) == 0) ? 4'($urandom) : '0;
      step();
    end
    idle();
    core_done = '0;
    repeat (6) step();
    chk("rand_queue_drained", 128'(rq.size() + mq.size()), 128'(0));

    // Reset one cycle after a read strobe
    set_reg(0, 1, 4'd1, '0, '0);
    set_mem(0, 1, 4'd2, '0, '0);
    step();
    idle();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_reg_rdvalid", 128'(hif.reg_rdvalid), 128'(0));
    chk("mid_rst_reg_rddata", 128'(hif.reg_rddata), 128'(0));
    chk("mid_rst_mem_rddata", hif.mem_rddata, 128'(0));
    chk("mid_rst_err", 128'(sts_err_cnt), 128'(0));
    chk("mid_rst_mask", 128'(sts_done_mask), 128'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    cyc++;
    rq.delete();
    mq.delete();
    m_err = 0;
    m_mask = '0;
    set_reg(0, 0, 0, '0, '0);
    set_mem(0, 0, 0, '0, '0);
    repeat (6) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
